snn_pool1d_stream: RTL and testbench
====================================

Name: snn_pool1d_stream

Overview:
- Next-generation 1D spike pooling layer for temporal SNN pipelines; sits downstream of snn_conv1d.
- Collects one timestep of spike events into a per-channel bitmap, then scans every (channel, output position) window and emits output spikes on AXI-Stream with full backpressure.
- Supports overlapping windows (STRIDE < POOL_SIZE), a run-time selectable AVG-threshold or MAX/OR mode, per-timestep bitmap clearing and an explicit end-of-timestep marker beat.

Parameters:
- INPUT_LENGTH, 128: positions per channel.
- INPUT_CHANNELS, 32: channel count, max 256.
- POOL_SIZE, 2: window width K, 1..16.
- STRIDE, 2: window step S, 1..POOL_SIZE.
- OUTPUT_LENGTH (localparam): (INPUT_LENGTH-POOL_SIZE)/STRIDE+1.
- CNT_WIDTH (localparam): $clog2(POOL_SIZE+1).

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- enable, in, 1: advance FSM; when low all state is frozen.
- s_axis_input_tvalid, in, 1: input spike valid.
- s_axis_input_tdata, in, 32: [31:16] position, [15:8] channel, [7:0] ignored.
- s_axis_input_tlast, in, 1: last spike of the timestep.
- s_axis_input_tready, out, 1: combinational, = enable && state==COLLECT.
- m_axis_output_tvalid, out, 1: output beat valid.
- m_axis_output_tdata, out, 32: spike beat {pos[15:0], ch[7:0], 7'b0, 1'b1}; marker beat 32'h0.
- m_axis_output_tlast, out, 1: high only on the marker beat.
- m_axis_output_tready, in, 1: downstream ready.
- config_valid, in, 1: start a timestep (sampled in IDLE only).
- config_data, in, 32: [7:0] threshold T, [8] mode (0 = AVG, 1 = MAX/OR); rest reserved.
- busy, out, 1: high in any state except IDLE.
- layer_done, out, 1: one-cycle pulse after the marker handshake.
- dropped_count, out, 16: out-of-range input spikes, saturating, cleared at each timestep start.

Behaviour:
- Reset: FSM to IDLE; bitmap (INPUT_CHANNELS words x INPUT_LENGTH bits) cleared; all outputs 0; latched config T=0, mode=0. A reset mid-operation abandons the timestep with no marker emitted.
- IDLE: on config_valid, latch T (T=0 treated as 1) and mode, clear dropped_count, go to COLLECT.
- COLLECT: on each input handshake with ch<INPUT_CHANNELS and pos<INPUT_LENGTH, set bitmap[ch][pos]. Otherwise drop the spike and increment dropped_count (saturates at 16'hFFFF). Duplicate spikes are idempotent.
- COLLECT exit: a handshake with tlast applies that beat's spike first, then goes to SCAN with ch=0, o=0.
- SCAN: over K cycles, add bitmap[ch][o*S+k] for k=0..K-1 into cnt (CNT_WIDTH, reset to 0 per window). Then one EVAL cycle.
- EVAL fire rule: AVG mode fires if cnt >= T (T > K never fires). MAX/OR mode fires if cnt >= 1.
- EVAL, fire: load the spike beat, assert tvalid, go to EMIT.
- EVAL, no fire: advance to the next window (see advance rule).
- EMIT: tdata and tvalid are held stable until tready. On the handshake, deassert tvalid and advance. tready may be high in the first EMIT cycle, giving a 1-cycle transfer.
- Advance rule: o<OUTPUT_LENGTH-1 gives o+1 and returns to SCAN. Otherwise go to CLEAR.
- CLEAR: one cycle; zero bitmap[ch]. If ch<INPUT_CHANNELS-1, set ch+1, o=0 and go to SCAN; else go to MARKER.
- Clearing happens only after every window of that channel is scanned, so overlapping windows always see the original bits.
- MARKER: drive tdata=0, tlast=1, tvalid=1; hold until tready, then clear tvalid/tlast and go to DONE.
- DONE: layer_done=1 for one cycle, then IDLE.
- Latency per window: K+1 cycles without a spike; K+2 minimum with a spike.
- Output order: channel-major, position ascending; the marker is always the final beat of a timestep, even with zero spikes.
- enable low: FSM, counters and outputs hold their values; held tvalid and tdata stay stable.

Test Plan:
- K=2, S=2, AVG, T=2; spikes (ch0,pos4), (ch0,pos5, tlast) -> exactly one beat 0x0002_0001, then marker 0x0 with tlast; layer_done pulses once.
- K=3, S=1, MAX/OR; spike (ch1,pos5) -> beats 0x0003_0101, 0x0004_0101, 0x0005_0101 in order, then marker.
- Same as case 1 with tready low for 5 cycles while tvalid is high -> tdata stays 0x0002_0001 throughout; exactly one transfer.
- Spikes (ch=INPUT_CHANNELS, pos0) and (ch0, pos=INPUT_LENGTH, tlast) -> only the marker beat; dropped_count=2.
- Two back-to-back timesteps: T1 spike (ch0,pos0)+(ch0,pos1), T2 only the marker -> T2 emits no spikes, proving the bitmap was cleared.
- Assert rst during EMIT -> tvalid, tlast, busy and layer_done go 0 immediately; the next timestep with no input spikes emits only the marker.

Source files
------------

// File: rtl/snn_pool1d_stream.sv
// 1D spike pooling: collects one timestep of spikes into a per-channel bitmap,
// then scans every (channel, window) and streams fired windows plus an end marker.
module snn_pool1d_stream #(
    parameter int INPUT_LENGTH   = 128,
    parameter int INPUT_CHANNELS = 32,
    parameter int POOL_SIZE      = 2,
    parameter int STRIDE         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s_axis_input_tvalid,
    input  logic [31:0] s_axis_input_tdata,
    input  logic        s_axis_input_tlast,
    output logic        s_axis_input_tready,
    output logic        m_axis_output_tvalid,
    output logic [31:0] m_axis_output_tdata,
    output logic        m_axis_output_tlast,
    input  logic        m_axis_output_tready,
    input  logic        config_valid,
    input  logic [31:0] config_data,
    output logic        busy,
    output logic        layer_done,
    output logic [15:0] dropped_count
);
    localparam int OUTPUT_LENGTH = (INPUT_LENGTH - POOL_SIZE) / STRIDE + 1;
    localparam int CNT_WIDTH     = $clog2(POOL_SIZE + 1);
    localparam int CH_W          = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;
    localparam int POS_W         = (INPUT_LENGTH > 1) ? $clog2(INPUT_LENGTH) : 1;

    typedef enum logic [2:0] {IDLE, COLLECT, SCAN, EVAL, EMIT, CLEAR, MARKER, DONE} state_t;

    state_t                  state;
    logic [INPUT_LENGTH-1:0] bitmap [INPUT_CHANNELS];
    logic [CH_W-1:0]         ch;
    logic [15:0]             o;
    logic [4:0]              k;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [7:0]              thr;
    logic                    mode;

    logic [15:0]      in_pos;
    logic [7:0]       in_ch;
    logic             in_ok;
    logic [POS_W-1:0] scan_pos;
    logic             fire;
    logic             last_win;
    logic             last_ch;
    logic             unused_bits;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A zero threshold would fire on empty windows; treat it as 1.
    function automatic logic [7:0] eff_thr(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

    assign in_pos      = s_axis_input_tdata[31:16];
    assign in_ch       = s_axis_input_tdata[15:8];
    assign in_ok       = (32'(in_ch) < INPUT_CHANNELS) && (32'(in_pos) < INPUT_LENGTH);
    assign scan_pos    = POS_W'(32'(o) * 32'(STRIDE) + 32'(k));
    assign fire        = mode ? (cnt != '0) : (32'(cnt) >= 32'(thr));
    assign last_win    = 32'(o) >= OUTPUT_LENGTH - 1;
    assign last_ch     = 32'(ch) >= INPUT_CHANNELS - 1;
    assign unused_bits = ^{s_axis_input_tdata[7:0], config_data[31:9]};

    assign s_axis_input_tready = enable && (state == COLLECT);
    assign busy                = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            for (int i = 0; i < INPUT_CHANNELS; i++) bitmap[i] <= '0;
            ch                   <= '0;
            o                    <= '0;
            k                    <= '0;
            cnt                  <= '0;
            thr                  <= '0;
            mode                 <= 1'b0;
            m_axis_output_tvalid <= 1'b0;
            m_axis_output_tdata  <= '0;
            m_axis_output_tlast  <= 1'b0;
            layer_done           <= 1'b0;
            dropped_count        <= '0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    layer_done <= 1'b0;
                    if (config_valid) begin
                        thr           <= eff_thr(config_data[7:0]);
                        mode          <= config_data[8];
                        dropped_count <= '0;
                        state         <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (s_axis_input_tvalid) begin
                        if (in_ok) bitmap[in_ch[CH_W-1:0]][in_pos[POS_W-1:0]] <= 1'b1;
                        else       dropped_count <= sat_inc16(dropped_count);
                        if (s_axis_input_tlast) begin
                            ch    <= '0;
                            o     <= '0;
                            k     <= '0;
                            cnt   <= '0;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    cnt <= cnt + CNT_WIDTH'(bitmap[ch][scan_pos]);
                    if (32'(k) == POOL_SIZE - 1) begin
                        k     <= '0;
                        state <= EVAL;
                    end else begin
                        k <= k + 5'd1;
                    end
                end
                EVAL: begin
                    cnt <= '0;
                    if (fire) begin
                        m_axis_output_tdata  <= {o, 8'(ch), 7'b0, 1'b1};
                        m_axis_output_tvalid <= 1'b1;
                        state                <= EMIT;
                    end else if (last_win) begin
                        state <= CLEAR;
                    end else begin
                        o     <= o + 16'd1;
                        state <= SCAN;
                    end
                end
                EMIT: begin
                    if (m_axis_output_tready) begin
                        m_axis_output_tvalid <= 1'b0;
                        if (last_win) begin
                            state <= CLEAR;
                        end else begin
                            o     <= o + 16'd1;
                            state <= SCAN;
                        end
                    end
                end
                // Clearing only after the channel's last window keeps overlapping windows exact.
                CLEAR: begin
                    bitmap[ch] <= '0;
                    if (last_ch) begin
                        m_axis_output_tdata  <= '0;
                        m_axis_output_tlast  <= 1'b1;
                        m_axis_output_tvalid <= 1'b1;
                        state                <= MARKER;
                    end else begin
                        ch    <= ch + CH_W'(1);
                        o     <= '0;
                        state <= SCAN;
                    end
                end
                MARKER: begin
                    if (m_axis_output_tready) begin
                        m_axis_output_tvalid <= 1'b0;
                        m_axis_output_tlast  <= 1'b0;
                        layer_done           <= 1'b1;
                        state                <= DONE;
                    end
                end
                DONE: begin
                    layer_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_pool1d_stream.sv
// Bench for snn_pool1d_stream: two instances (K=2,S=2 and K=3,S=1) checked against a
// window-counting model of the expected beat stream plus literal expectations.
module tb_snn_pool1d_stream;
    localparam int L = 16;
    localparam int C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, en, in_valid, in_last, out_ready, cfg_valid;
    logic [1:0]  in_ready, out_valid, out_last, busy, done;
    logic [31:0] in_data [2];
    logic [31:0] cfg_data [2];
    logic [31:0] out_data [2];
    logic [15:0] dropped [2];

    snn_pool1d_stream #(.INPUT_LENGTH(L), .INPUT_CHANNELS(C), .POOL_SIZE(2), .STRIDE(2)) dut_a (
        .clk(clk), .rst(rst[0]), .enable(en[0]),
        .s_axis_input_tvalid(in_valid[0]), .s_axis_input_tdata(in_data[0]),
        .s_axis_input_tlast(in_last[0]), .s_axis_input_tready(in_ready[0]),
        .m_axis_output_tvalid(out_valid[0]), .m_axis_output_tdata(out_data[0]),
        .m_axis_output_tlast(out_last[0]), .m_axis_output_tready(out_ready[0]),
        .config_valid(cfg_valid[0]), .config_data(cfg_data[0]),
        .busy(busy[0]), .layer_done(done[0]), .dropped_count(dropped[0]));

    snn_pool1d_stream #(.INPUT_LENGTH(L), .INPUT_CHANNELS(C), .POOL_SIZE(3), .STRIDE(1)) dut_b (
        .clk(clk), .rst(rst[1]), .enable(en[1]),
        .s_axis_input_tvalid(in_valid[1]), .s_axis_input_tdata(in_data[1]),
        .s_axis_input_tlast(in_last[1]), .s_axis_input_tready(in_ready[1]),
        .m_axis_output_tvalid(out_valid[1]), .m_axis_output_tdata(out_data[1]),
        .m_axis_output_tlast(out_last[1]), .m_axis_output_tready(out_ready[1]),
        .config_valid(cfg_valid[1]), .config_data(cfg_data[1]),
        .busy(busy[1]), .layer_done(done[1]), .dropped_count(dropped[1]));

    int tests = 0;
    int fails = 0;

    logic [L-1:0] mbm [C];
    int           exp_drop;
    logic [7:0]   cur_t;
    logic         cur_m;
    logic [32:0]  expq [$];
    logic [31:0]  got [$];
    int           done_seen [2];
    bit           held_v [2];
    logic [31:0]  held [2];
    logic [32:0]  e;

    function automatic int kof(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int sof(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: count set bits per window from the spike set, emit every firing window, then the marker.
    function automatic void model_emit(int i);
        int kk = kof(i);
        int ss = sof(i);
        int ol = (L - kk) / ss + 1;
        int te = (cur_t == 8'd0) ? 1 : int'(cur_t);
        for (int c = 0; c < C; c++) begin
            for (int w = 0; w < ol; w++) begin
                int cnt = 0;
                for (int j = 0; j < kk; j++) cnt += int'(mbm[c][w * ss + j]);
                if (cur_m ? (cnt >= 1) : (cnt >= te))
                    expq.push_back({1'b0, 16'(w), 8'(c), 8'h01});
            end
        end
        expq.push_back(33'h1_0000_0000);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                held_v[i] = 1'b0;
            end else begin
                if (out_valid[i]) begin
                    if (held_v[i]) check($sformatf("hold_tdata%0d", i), out_data[i], held[i]);
                    if (out_ready[i]) begin
                        if (expq.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_beat%0d: got 0x%08h, expected no beat", i, out_data[i]);
                        end else begin
                            e = expq.pop_front();
                            check($sformatf("beat%0d", i), out_data[i], e[31:0]);
                            check($sformatf("tlast%0d", i), {31'b0, out_last[i]}, {31'b0, e[32]});
                        end
                        got.push_back(out_data[i]);
                        held_v[i] = 1'b0;
                    end else begin
                        held[i]   = out_data[i];
                        held_v[i] = 1'b1;
                    end
                end else begin
                    held_v[i] = 1'b0;
                end
                if (done[i]) done_seen[i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(int i, logic [7:0] t, logic m);
        for (int c = 0; c < C; c++) mbm[c] = '0;
        exp_drop = 0;
        cur_t    = t;
        cur_m    = m;
        got.delete();
        cfg_data[i]  = {23'b0, m, t};
        cfg_valid[i] = 1'b1;
        tick();
        cfg_valid[i] = 1'b0;
        check($sformatf("busy_after_cfg%0d", i), {31'b0, busy[i]}, 32'd1);
    endtask

    task automatic send(int i, int ch, int pos, logic last);
        int n = 0;
        in_data[i]  = {16'(pos), 8'(ch), 8'h00};
        in_valid[i] = 1'b1;
        in_last[i]  = last;
        while (!in_ready[i] && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready[i]) begin
            tests++;
            fails++;
            $display("FAIL send_timeout%0d: tready 0, expected 1", i);
        end
        tick();
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        if (ch < C && pos < L) mbm[ch][pos] = 1'b1;
        else exp_drop++;
        if (last) model_emit(i);
    endtask

    task automatic finish_ts(int i, string tag);
        int base = done_seen[i];
        int n = 0;
        while (busy[i] && n < 3000) begin
            tick();
            n++;
        end
        if (busy[i]) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy 1, expected 0", tag);
        end
        tick();
        check({tag, "_layer_done"}, 32'(done_seen[i] - base), 32'd1);
        check({tag, "_queue_left"}, 32'(expq.size()), 32'd0);
        check({tag, "_dropped"}, {16'b0, dropped[i]}, 32'(exp_drop));
    endtask

    task automatic wait_valid(int i, string tag);
        int n = 0;
        while (!out_valid[i] && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_tvalid_seen"}, {31'b0, out_valid[i]}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 2'b11; en = 2'b11; in_valid = 2'b00; in_last = 2'b00;
        out_ready = 2'b11; cfg_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            in_data[i]  = '0;
            cfg_data[i] = '0;
        end
        tick(); tick(); tick();
        rst = 2'b00;
        tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_tvalid%0d", i), {31'b0, out_valid[i]}, 32'd0);
            check($sformatf("rst_tlast%0d", i), {31'b0, out_last[i]}, 32'd0);
            check($sformatf("rst_busy%0d", i), {31'b0, busy[i]}, 32'd0);
            check($sformatf("rst_done%0d", i), {31'b0, done[i]}, 32'd0);
            check($sformatf("rst_tready%0d", i), {31'b0, in_ready[i]}, 32'd0);
            check($sformatf("rst_dropped%0d", i), {16'b0, dropped[i]}, 32'd0);
        end

        // K=2,S=2, AVG T=2: window 2 holds both spikes
        start(0, 8'd2, 1'b0);
        send(0, 0, 4, 1'b0);
        send(0, 0, 5, 1'b1);
        check("c1_model_size", 32'(expq.size()), 32'd2);
        check("c1_model_beat", expq[0][31:0], 32'h0002_0001);
        finish_ts(0, "c1");
        check("c1_got_n", 32'(got.size()), 32'd2);
        check("c1_got0", got[0], 32'h0002_0001);
        check("c1_got1", got[1], 32'h0);

        // K=3,S=1, MAX: spike at pos5 lands in windows 3,4,5
        start(1, 8'd0, 1'b1);
        send(1, 1, 5, 1'b1);
        finish_ts(1, "c2");
        check("c2_got_n", 32'(got.size()), 32'd4);
        check("c2_got0", got[0], 32'h0003_0101);
        check("c2_got1", got[1], 32'h0004_0101);
        check("c2_got2", got[2], 32'h0005_0101);
        check("c2_got3", got[3], 32'h0);

        // backpressure for 5 cycles, with enable dropped for two of them
        out_ready[0] = 1'b0;
        start(0, 8'd2, 1'b0);
        send(0, 0, 4, 1'b0);
        send(0, 0, 5, 1'b1);
        wait_valid(0, "c3");
        for (int j = 0; j < 5; j++) begin
            check($sformatf("c3_stall_tdata%0d", j), out_data[0], 32'h0002_0001);
            check($sformatf("c3_stall_tvalid%0d", j), {31'b0, out_valid[0]}, 32'd1);
            en[0] = (j == 1 || j == 2) ? 1'b0 : 1'b1;
            tick();
        end
        en[0] = 1'b1;
        out_ready[0] = 1'b1;
        finish_ts(0, "c3");
        check("c3_got_n", 32'(got.size()), 32'd2);

        // out-of-range channel and position are both dropped
        start(0, 8'd0, 1'b0);
        send(0, C, 0, 1'b0);
        send(0, 0, L, 1'b1);
        finish_ts(0, "c4");
        check("c4_dropped_lit", {16'b0, dropped[0]}, 32'd2);
        check("c4_got_n", 32'(got.size()), 32'd1);

        // back-to-back: second timestep would fire only if pos1 survived
        start(0, 8'd2, 1'b0);
        send(0, 0, 0, 1'b0);
        send(0, 0, 1, 1'b1);
        finish_ts(0, "c5a");
        check("c5a_got0", got[0], 32'h0000_0001);
        start(0, 8'd2, 1'b0);
        send(0, 0, 0, 1'b1);
        finish_ts(0, "c5b");
        check("c5b_got_n", 32'(got.size()), 32'd1);

        // threshold 0 acts as 1; threshold above K never fires
        start(0, 8'd0, 1'b0);
        send(0, 2, 7, 1'b1);
        finish_ts(0, "c7");
        check("c7_got0", got[0], 32'h0003_0201);
        start(0, 8'd3, 1'b0);
        send(0, 0, 0, 1'b0);
        send(0, 0, 1, 1'b1);
        finish_ts(0, "c8");
        check("c8_got_n", 32'(got.size()), 32'd1);

        // reset while a beat is stalled in EMIT
        out_ready[0] = 1'b0;
        start(0, 8'd2, 1'b0);
        send(0, 0, 4, 1'b0);
        send(0, 0, 5, 1'b1);
        wait_valid(0, "c6");
        #2;
        rst[0] = 1'b1;
        #1;
        check("c6_rst_tvalid", {31'b0, out_valid[0]}, 32'd0);
        check("c6_rst_tlast", {31'b0, out_last[0]}, 32'd0);
        check("c6_rst_busy", {31'b0, busy[0]}, 32'd0);
        check("c6_rst_done", {31'b0, done[0]}, 32'd0);
        expq.delete();
        tick();
        rst[0] = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        start(0, 8'd2, 1'b0);
        send(0, C, 0, 1'b1);
        finish_ts(0, "c6");
        check("c6_got_n", 32'(got.size()), 32'd1);
        check("c6_got0", got[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
